pipelined_math_unit: RTL and testbench

Parametrised, two-stage pipelined three-operand arithmetic unit computing Z = A ±B ±C on signed two's-complement operands, with a per-transaction mode select, wrap-or-saturate result handling, an overflow flag, and valid/ready handshakes on both sides. It is the next generation of the combinational A+B−C math unit in the GATES library. It sits between an operand source and a result consumer that may stall.

---
 rtl/pipelined_math_unit_if.sv | 11 +
 rtl/pipelined_math_unit.sv | 55 +++++
 tb/tb_pipelined_math_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_math_unit_if.sv
// pipelined_math_unit_if: operand/result handshake bundle for pipelined_math_unit
interface pipelined_math_unit_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready;
  logic [WIDTH-1:0] a, b, c;
  logic [1:0] mode;
  logic out_valid, out_ready;
  logic [WIDTH-1:0] z;
  logic ovf;
  modport master (output in_valid, a, b, c, mode, out_ready, input in_ready, out_valid, z, ovf);
  modport slave (input in_valid, a, b, c, mode, out_ready, output in_ready, out_valid, z, ovf);
endinterface

// File: rtl/pipelined_math_unit.sv
// pipelined_math_unit: two-stage Z = A +/- B +/- C with wrap/saturate and overflow flag
module pipelined_math_unit #(
  parameter int WIDTH = 16,
  parameter bit SAT = 1'b0
) (
  input logic clk,
  input logic rst,
  pipelined_math_unit_if.slave io
);
  logic v1, v2, m1, ovf, adv2, take, e_ovf;
  logic [WIDTH:0] s1;
  logic [WIDTH-1:0] c1, z, zn;
  logic [WIDTH+1:0] e;
  always_comb begin
    adv2 = v1 && (!v2 || io.out_ready);
    io.in_ready = !v1 || adv2;
    take = io.in_valid && io.in_ready;
    e = m1 ? {s1[WIDTH], s1} + {{2{c1[WIDTH-1]}}, c1} : {s1[WIDTH], s1} - {{2{c1[WIDTH-1]}}, c1};
    // exact result fits in WIDTH bits only when the top three bits agree
    e_ovf = !(e[WIDTH+1:WIDTH-1] == '0 || e[WIDTH+1:WIDTH-1] == '1);
    zn = (SAT && e_ovf) ? {e[WIDTH+1], {(WIDTH-1){!e[WIDTH+1]}}} : e[WIDTH-1:0];
    io.out_valid = v2;
    io.z = z;
    io.ovf = ovf;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      s1 <= '0;
      c1 <= '0;
      m1 <= 1'b0;
    end else if (take) begin
      v1 <= 1'b1;
      s1 <= io.mode[1] ? {io.a[WIDTH-1], io.a} - {io.b[WIDTH-1], io.b}
                       : {io.a[WIDTH-1], io.a} + {io.b[WIDTH-1], io.b};
      c1 <= io.c;
      m1 <= io.mode[0];
    end else if (adv2) begin
      v1 <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
      z <= '0;
      ovf <= 1'b0;
    end else if (adv2) begin
      v2 <= 1'b1;
      z <= zn;
      ovf <= e_ovf;
    end else if (io.out_ready) begin
      v2 <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pipelined_math_unit.sv
// tb_pipelined_math_unit: scoreboard bench driving a wrapping and a saturating unit in lockstep
module tb_pipelined_math_unit;
  typedef struct packed {logic [15:0] a, b, c; logic [1:0] m; logic [15:0] z0, z1; logic o;} vec_t;
  typedef struct packed {logic [15:0] z; logic ovf;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, errors = 0, nout = 0, base = 0;
  exp_t q0[$], q1[$];
  exp_t me0, me1;
  logic acc;
  logic [15:0] zs;
  vec_t tbl[9] = '{
    '{16'h0005, 16'h0003, 16'h0002, 2'b00, 16'h0006, 16'h0006, 1'b0},
    '{16'hFFFC, 16'h0003, 16'h000A, 2'b11, 16'h0003, 16'h0003, 1'b0},
    '{16'h7FFF, 16'h0001, 16'h0000, 2'b01, 16'h8000, 16'h7FFF, 1'b1},
    '{16'h8000, 16'h0001, 16'h0001, 2'b10, 16'h7FFE, 16'h8000, 1'b1},
    '{16'h7FFF, 16'h0001, 16'h0001, 2'b00, 16'h7FFF, 16'h7FFF, 1'b0},
    '{16'h8000, 16'h8000, 16'h8000, 2'b01, 16'h8000, 16'h8000, 1'b1},
    '{16'h8000, 16'h7FFF, 16'h8000, 2'b10, 16'h8001, 16'h8001, 1'b0},
    '{16'h1234, 16'h1111, 16'h0123, 2'b11, 16'h0246, 16'h0246, 1'b0},
    '{16'h7FFF, 16'h8000, 16'h7FFF, 2'b11, 16'h7FFE, 16'h7FFF, 1'b1}
  };

  pipelined_math_unit_if #(.WIDTH(16)) i0 ();
  pipelined_math_unit_if #(.WIDTH(16)) i1 ();
  pipelined_math_unit #(.WIDTH(16), .SAT(1'b0)) u0 (.clk(clk), .rst(rst), .io(i0.slave));
  pipelined_math_unit #(.WIDTH(16), .SAT(1'b1)) u1 (.clk(clk), .rst(rst), .io(i1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] a, b, c, input logic [1:0] m);
    int ia = $signed(a);
    int ib = $signed(b);
    int ic = $signed(c);
    int e = ia + (m[1] ? -ib : ib) + (m[0] ? ic : -ic);
    vec_t v;
    v.a = a; v.b = b; v.c = c; v.m = m;
    v.o = (e > 32767) || (e < -32768);
    v.z0 = e[15:0];
    v.z1 = (e > 32767) ? 16'h7FFF : (e < -32768) ? 16'h8000 : e[15:0];
    return v;
  endfunction

  task automatic drive(input logic val, input vec_t v, input logic ordy);
    i0.in_valid = val; i0.a = v.a; i0.b = v.b; i0.c = v.c; i0.mode = v.m; i0.out_ready = ordy;
    i1.in_valid = val; i1.a = v.a; i1.b = v.b; i1.c = v.c; i1.mode = v.m; i1.out_ready = ordy;
  endtask

  task automatic step(input logic val, input vec_t v, input logic ordy, output logic ok);
    @(negedge clk);
    drive(val, v, ordy);
    #1;
    ok = val && i0.in_ready;
    if (ok) begin
      q0.push_back('{z: v.z0, ovf: v.o});
      q1.push_back('{z: v.z1, ovf: v.o});
    end
  endtask

  task automatic send(input vec_t v, input bit rnd);
    logic ok;
    for (int t = 0; t < 64; t++) begin
      step(1'b1, v, rnd ? 1'($urandom_range(0, 1)) : 1'b1, ok);
      if (ok) return;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: in_ready never high within 64 cycles at %0t", $time);
  endtask

  task automatic idle(input int n);
    logic ok;
    for (int t = 0; t < n; t++) step(1'b0, tbl[0], 1'b1, ok);
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst && i0.out_valid && i0.out_ready) begin
      nout++;
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL sat0_unexpected: output z=%0h with nothing pending", i0.z);
      end else begin
        me0 = q0.pop_front();
        chk("sat0_z", 32'(i0.z), 32'(me0.z));
        chk("sat0_ovf", 32'(i0.ovf), 32'(me0.ovf));
      end
    end
    if (!rst && i1.out_valid && i1.out_ready) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL sat1_unexpected: output z=%0h with nothing pending", i1.z);
      end else begin
        me1 = q1.pop_front();
        chk("sat1_z", 32'(i1.z), 32'(me1.z));
        chk("sat1_ovf", 32'(i1.ovf), 32'(me1.ovf));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, tbl[0], 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(i0.out_valid), 0);
    chk("rst_z", 32'(i0.z), 0);
    chk("rst_ovf", 32'(i1.ovf), 0);
    chk("rst_in_ready", 32'(i0.in_ready), 1);
    // latency: result visible two edges after operands are presented
    send(tbl[0], 1'b0);
    @(negedge clk);
    drive(1'b0, tbl[0], 1'b1);
    #1;
    chk("lat_edge1_valid", 32'(i0.out_valid), 0);
    @(negedge clk);
    #1;
    chk("lat_edge2_valid", 32'(i0.out_valid), 1);
    chk("lat_edge2_z", 32'(i0.z), 32'h0006);
    idle(2);
    #3;
    base = nout;
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, tbl[k], 1'b1, acc);
      chk("b2b_accept", 32'(acc), 1);
      chk("b2b_out_valid", 32'(i0.out_valid), (k >= 3) ? 1 : 0);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, tbl[0], 1'b1, acc);
      chk("b2b_tail_valid", 32'(i0.out_valid), (k < 2) ? 1 : 0);
    end
    #3;
    chk("b2b_count", 32'(nout - base), 8);
    // stall: two accepts fill the pipe, third is refused, output held
    step(1'b1, tbl[1], 1'b0, acc);
    chk("stall_acc1", 32'(acc), 1);
    step(1'b1, tbl[2], 1'b0, acc);
    chk("stall_acc2", 32'(acc), 1);
    step(1'b1, tbl[3], 1'b0, acc);
    chk("stall_acc3", 32'(acc), 0);
    chk("stall_in_ready", 32'(i0.in_ready), 0);
    zs = i0.z;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, tbl[3], 1'b0, acc);
      chk("stall_hold_acc", 32'(acc), 0);
      chk("stall_z_stable", 32'(i0.z), 32'(zs));
      chk("stall_valid", 32'(i0.out_valid), 1);
    end
    idle(3);
    #3;
    chk("stall_drain_q0", 32'(q0.size()), 0);
    chk("stall_drain_q1", 32'(q1.size()), 0);
    for (int k = 0; k < 100; k++)
      send(mk(16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom)), 1'b1);
    idle(4);
    #3;
    chk("rand_drain_q0", 32'(q0.size()), 0);
    chk("rand_drain_q1", 32'(q1.size()), 0);
    // reset with both stages full discards them
    step(1'b1, tbl[0], 1'b0, acc);
    step(1'b1, tbl[4], 1'b0, acc);
    chk("rst_fill_acc", 32'(acc), 1);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, tbl[0], 1'b0);
    q0.delete();
    q1.delete();
    base = nout;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(i0.out_valid), 0);
    chk("midrst_z", 32'(i0.z), 0);
    chk("midrst_ovf", 32'(i0.ovf), 0);
    chk("midrst_in_ready", 32'(i0.in_ready), 1);
    idle(4);
    #3;
    chk("midrst_no_stale", 32'(nout - base), 0);
    send(tbl[8], 1'b0);
    idle(4);
    #3;
    chk("final_drain", 32'(q0.size() + q1.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
